ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- EX-stage consumer of the ID/EX latch outputs. Executes MIPS MULT/MULTU/DIV/DIVU iteratively into HI/LO registers, services MFHI/MFLO/MTHI/MTLO, and back-pressures the ID/EX latch while busy.
- Sits beside the ALU. Operands come from the latched read data (post-forwarding); the opcode comes from the latched funct bits.

Parameters:
- XLEN, 32, operand/HI/LO width
- ITERS, 32, iterations per mul/div (must equal XLEN)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  ID/EX entry holds a real instruction (0 = bubble)
- rtype  in  1  latched EX control decodes as R-type
- instr_funct  in  6  latched funct field
- opa  in  32  rs operand
- opb  in  32  rt operand
- stall  out  1  hold PC, IF/ID and ID/EX; insert bubble downstream
- busy  out  1  mul/div in progress
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- hilo_rd_en  out  1  current EX op is MFHI/MFLO and is not stalled
- hilo_rd_data  out  32  HI for MFHI, LO for MFLO, else 0

Behaviour:
- Decode, only when op_valid & rtype: funct 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO. hilo_op = any of these 8. All other funct values are ignored by this block.
- stall = busy & hilo_op (combinational). Non-HI/LO instructions flow during a mul/div.
- FSM states IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE + mul/div op: latch |opa| and |opb| (signed ops) or raw values (unsigned), latch result-sign flags, cnt=0, go to CALC.
- CALC: one shift-add (mul) or restoring-subtract (div) step per cycle. cnt increments; after the step at cnt=ITERS-1, go to FIX.
- FIX: apply two's-complement negation where needed, write HI/LO, go to IDLE.
  - MULT: negate the 64-bit product if signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- Latency: issue edge E0, 32 CALC edges, FIX edge E33 writes HI/LO. busy is high for exactly 33 cycles. A stalled MF* sees the new HI/LO in the cycle busy falls.
- MTHI/MTLO in IDLE: write opa to HI/LO at the edge. MFHI/MFLO in IDLE: hilo_rd_data is the current register value, combinational, same cycle.
- Divide by zero (opb==0, signed or unsigned): LO=0xFFFFFFFF, HI=opa unmodified, full latency, no sign fixup.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the abs/negate path.
- MULTU uses a 64-bit accumulator. abs(0x80000000) is treated as unsigned 0x80000000.
- Same-edge cases:
  - A hilo_op arriving on the FIX cycle is stalled (busy=1) and accepted next cycle.
  - A hilo_op held by stall is accepted exactly once.
- Reset (any state, including mid-CALC): state=IDLE, cnt=0, HI=LO=0, stall=busy=hilo_rd_en=0, hilo_rd_data=0. Any in-flight operation is discarded.

Decomposition:
- Shared package (ex_pkg):
  - Funct constants FN_MULT..FN_MTLO.
  - mdu_state_t enum {IDLE, CALC, FIX}.
  - XLEN constant.
- One sub-module, muldiv_iter: the iterative datapath (accumulator/remainder shift, add/subtract step, final negate), driven by start/step/fix strobes.
- FSM, decode, stall logic and HI/LO registers stay in the top.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=7 -> busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT then MFLO on the next cycle -> stall=1 for 33 cycles. On the first non-stalled cycle: hilo_rd_en=1, hilo_rd_data = new LO.
- MULT then an ADD (funct 0x20) on the next cycle -> stall=0 and hilo_rd_en=0. A later MFLO gets the correct product.
- DIVU 100/7 with rst pulsed at cycle 10 -> next cycle busy=0, HI=LO=0. MTLO 0x1234 -> LO=0x1234 after one edge; MFLO -> hilo_rd_data=0x1234.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
package ex_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with final sign fixup.
// acc holds the running product (mul) or {remainder, quotient} (div).
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = ex_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            fix,
  input  logic            is_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] res_hi_c,
  output logic [XLEN-1:0] res_lo_c
);

  localparam int unsigned AW = 2 * XLEN;

  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] m_q, m_d;
  logic            div_q, div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;

  logic            dz;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   sum, rs;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] q_fix, r_fix;

  // Operand conditioning; a zero divisor keeps the raw dividend so HI ends up unmodified.
  always_comb begin
    dz    = is_div && (opb == '0);
    a_abs = (is_signed && !dz && opa[XLEN-1]) ? -opa : opa;
    b_abs = (is_signed && opb[XLEN-1]) ? -opb : opb;
  end

  // One iteration step, the sign fixup and the next-state of the datapath.
  always_comb begin
    sum      = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rs       = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    ge       = (rs >= {1'b0, m_q});
    diff     = rs[XLEN-1:0] - m_q;
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    q_fix    = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_fix    = neg_hi_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    res_hi_c = div_q ? r_fix : prod_fix[AW-1:XLEN];
    res_lo_c = div_q ? q_fix : prod_fix[XLEN-1:0];

    acc_d    = acc_q;
    m_d      = m_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (start) begin
      m_d      = is_div ? b_abs : a_abs;
      acc_d    = {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
      div_d    = is_div;
      neg_lo_d = is_signed && !dz && (opa[XLEN-1] ^ opb[XLEN-1]);
      neg_hi_d = is_div && is_signed && !dz && opa[XLEN-1];
    end else if (step) begin
      if (div_q) begin
        acc_d = {(ge ? diff : rs[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      end else begin
        acc_d = {sum, acc_q[XLEN-1:1]};
      end
    end else if (fix) begin
      acc_d = {res_hi_c, res_lo_c};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      m_q      <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: decode, mul/div sequencing, pipeline stall and HI/LO registers.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int unsigned XLEN  = ex_pkg::XLEN,
  parameter int unsigned ITERS = ex_pkg::ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            rtype,
  input  logic [5:0]      instr_funct,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            hilo_rd_en,
  output logic [XLEN-1:0] hilo_rd_data
);

  localparam int unsigned CNT_W = $clog2(ITERS);

  mdu_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic sel, is_md, is_signed, is_div, mf_hi, mf_lo, mt_hi, mt_lo, hilo_op;
  logic start, step, fix;
  logic [XLEN-1:0] res_hi_c, res_lo_c;

  // Instruction decode; bubbles and non-R-type entries are ignored.
  always_comb begin
    sel       = op_valid && rtype;
    is_signed = (instr_funct == FN_MULT) || (instr_funct == FN_DIV);
    is_div    = (instr_funct == FN_DIV) || (instr_funct == FN_DIVU);
    is_md     = sel && (is_signed || is_div || (instr_funct == FN_MULTU));
    mf_hi     = sel && (instr_funct == FN_MFHI);
    mf_lo     = sel && (instr_funct == FN_MFLO);
    mt_hi     = sel && (instr_funct == FN_MTHI);
    mt_lo     = sel && (instr_funct == FN_MTLO);
    hilo_op   = is_md || mf_hi || mf_lo || mt_hi || mt_lo;
  end

  // Status, stall and HI/LO read port.
  always_comb begin
    busy         = !rst && (state_q != IDLE);
    stall        = busy && hilo_op;
    hilo_rd_en   = !rst && (mf_hi || mf_lo) && !stall;
    hilo_rd_data = rst ? '0 : (mf_hi ? hi_q : (mf_lo ? lo_q : '0));
    hi_out       = hi_q;
    lo_out       = lo_q;
  end

  // Next-state logic for the sequencer and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
        if (mt_hi) hi_d = opa;
        if (mt_lo) lo_d = opa;
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        hi_d    = res_hi_c;
        lo_d    = res_lo_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step      (step),
    .fix       (fix),
    .is_div    (is_div),
    .is_signed (is_signed),
    .opa       (opa),
    .opb       (opb),
    .res_hi_c  (res_hi_c),
    .res_lo_c  (res_lo_c)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table, hand sequences, random vs. model.
module tb_ex_muldiv_unit;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        rtype;
  logic [5:0]  instr_funct;
  logic [31:0] opa, opb;
  logic        stall, busy, hilo_rd_en;
  logic [31:0] hi_out, lo_out, hilo_rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_muldiv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .rtype        (rtype),
    .instr_funct  (instr_funct),
    .opa          (opa),
    .opb          (opb),
    .stall        (stall),
    .busy         (busy),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .hilo_rd_en   (hilo_rd_en),
    .hilo_rd_data (hilo_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string nm, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.name = nm; v.fn = fn; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  // Reference: MIPS HI/LO semantics using wide plain arithmetic.
  function automatic void model(input logic [5:0] fn, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (fn)
      FN_MULT: begin
        p = sa * sb;
        hi = p[63:32]; lo = p[31:0];
      end
      FN_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        hi = u[63:32]; lo = u[31:0];
      end
      FN_DIV: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b; lo = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rt, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    op_valid = v; rtype = rt; instr_funct = fn; opa = a; opb = b;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Issue one mul/div and count busy cycles until it drains (bounded).
  task automatic run_md(input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, output int nb);
    drive(1'b1, 1'b1, fn, a, b);
    tick();
    bubble();
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      tick();
    end
  endtask

  // Hold the current inputs and count stalled cycles (bounded).
  task automatic count_stall(output int ns);
    ns = 0;
    while (stall === 1'b1 && ns < 100) begin
      ns++;
      tick();
    end
  endtask

  int          nb, ns;
  logic [31:0] ehi, elo;
  logic [5:0]  fns[4];

  initial begin
    vecs[0] = mk("mult_neg3x7",   FN_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    vecs[1] = mk("multu_max",     FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    vecs[2] = mk("div_neg7_2",    FN_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    vecs[3] = mk("divu_by0",      FN_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    vecs[4] = mk("div_min_neg1",  FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    vecs[5] = mk("divu_100_7",    FN_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
    vecs[6] = mk("mult_min_min",  FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    vecs[7] = mk("div_7_neg2",    FN_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    vecs[8] = mk("div_neg5_by0",  FN_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    vecs[9] = mk("multu_min_2",   FN_MULTU, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000);
    fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;

    // Reset; an MFHI presented during reset must not read.
    rst = 1'b1;
    bubble();
    tick();
    drive(1'b1, 1'b1, FN_MFHI, 32'h0, 32'h0);
    #1;
    chk("rst_rd_en", 32'(hilo_rd_en), 32'd0);
    chk("rst_rd_data", hilo_rd_data, 32'd0);
    tick();
    bubble();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    rst = 1'b0;
    tick();

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_md(vecs[i].fn, vecs[i].a, vecs[i].b, nb);
      chk({vecs[i].name, "_busy_cycles"}, 32'(nb), 32'd33);
      chk({vecs[i].name, "_hi"}, hi_out, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo_out, vecs[i].lo);
    end

    // Same-cycle MFHI in idle.
    drive(1'b1, 1'b1, FN_MFHI, 32'h0, 32'h0);
    #1;
    chk("idle_mfhi_en", 32'(hilo_rd_en), 32'd1);
    chk("idle_mfhi_data", hilo_rd_data, 32'h0000_0001);
    tick();

    // Non-R-type and bubble entries are ignored.
    drive(1'b1, 1'b0, FN_MULT, 32'd3, 32'd3);
    tick();
    chk("nonr_mult_busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b1, FN_MTLO, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("bubble_mtlo_lo", lo_out, 32'h0);

    // MULT followed by a stalled MFLO.
    drive(1'b1, 1'b1, FN_MULT, 32'hFFFF_FFFD, 32'd7);
    tick();
    drive(1'b1, 1'b1, FN_MFLO, 32'h0, 32'h0);
    #1;
    chk("mflo_stalled_en", 32'(hilo_rd_en), 32'd0);
    count_stall(ns);
    chk("mflo_stall_cycles", 32'(ns), 32'd33);
    chk("mflo_release_en", 32'(hilo_rd_en), 32'd1);
    chk("mflo_release_data", hilo_rd_data, 32'hFFFF_FFEB);
    tick();

    // MULT followed by a stalled MTLO: written once, after the product.
    drive(1'b1, 1'b1, FN_MULT, 32'd6, 32'd7);
    tick();
    drive(1'b1, 1'b1, FN_MTLO, 32'h0000_ABCD, 32'h0);
    #1;
    count_stall(ns);
    chk("mtlo_stall_cycles", 32'(ns), 32'd33);
    chk("mtlo_held_lo", lo_out, 32'd42);
    chk("mtlo_held_hi", hi_out, 32'd0);
    tick();
    bubble();
    chk("mtlo_accepted_lo", lo_out, 32'h0000_ABCD);

    // MULT followed by a non-HI/LO instruction flows through.
    drive(1'b1, 1'b1, FN_MULT, 32'd9, 32'd11);
    tick();
    drive(1'b1, 1'b1, 6'h20, 32'd1, 32'd2);
    #1;
    chk("add_stall", 32'(stall), 32'd0);
    chk("add_rd_en", 32'(hilo_rd_en), 32'd0);
    tick();
    bubble();
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      tick();
    end
    chk("add_drain_cycles", 32'(nb), 32'd32);
    drive(1'b1, 1'b1, FN_MFLO, 32'h0, 32'h0);
    #1;
    chk("add_mflo_en", 32'(hilo_rd_en), 32'd1);
    chk("add_mflo_data", hilo_rd_data, 32'd99);
    tick();

    // Reset in the middle of a DIVU discards it.
    drive(1'b1, 1'b1, FN_DIVU, 32'd100, 32'd7);
    tick();
    bubble();
    repeat (9) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    repeat (40) tick();
    chk("midrst_discard_lo", lo_out, 32'd0);
    drive(1'b1, 1'b1, FN_MTLO, 32'h0000_1234, 32'h0);
    tick();
    chk("mtlo_lo", lo_out, 32'h0000_1234);
    drive(1'b1, 1'b1, FN_MFLO, 32'h0, 32'h0);
    #1;
    chk("mflo_data", hilo_rd_data, 32'h0000_1234);
    tick();
    drive(1'b1, 1'b1, FN_MTHI, 32'h0000_5678, 32'h0);
    tick();
    drive(1'b1, 1'b1, FN_MFHI, 32'h0, 32'h0);
    #1;
    chk("mfhi_data", hilo_rd_data, 32'h0000_5678);
    tick();
    bubble();

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  fn;
      logic [31:0] a, b;
      fn = fns[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      run_md(fn, a, b, nb);
      model(fn, a, b, ehi, elo);
      chk($sformatf("rnd%0d_busy fn=%02h", i, fn), 32'(nb), 32'd33);
      chk($sformatf("rnd%0d_hi fn=%02h a=%08h b=%08h", i, fn, a, b), hi_out, ehi);
      chk($sformatf("rnd%0d_lo fn=%02h a=%08h b=%08h", i, fn, a, b), lo_out, elo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
